// File: rtl/chrono_pkg.sv
//------------------------------------------------------------------------------
// chrono_pkg : shared state encoding, field widths and limits for chrono_counter
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package chrono_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam int MIN_W  = 4;
  localparam int SEG_W  = 6;
  localparam int CENT_W = 7;

  localparam logic [CENT_W-1:0] CENT_MAX = 7'd99;
  localparam logic [SEG_W-1:0]  SEG_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 4'd9;

  function automatic logic at_full_scale(input logic [MIN_W-1:0]  m,
                                         input logic [SEG_W-1:0]  s,
                                         input logic [CENT_W-1:0] c);
    return (m == MIN_MAX) && (s == SEG_MAX) && (c == CENT_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
//------------------------------------------------------------------------------
// edge_sync : optional 2-flop synchronizer (CHRONO_SYNC_EN) + rising-edge detect
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

`ifdef CHRONO_SYNC_EN
  localparam logic [1:0] ARM_CYCLES = 2'd3;

  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       cur;

  always_comb begin
    sync_d = {sync_q[0], i_sig};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign cur = sync_q[1];
`else
  localparam logic [1:0] ARM_CYCLES = 2'd1;

  logic cur;

  assign cur = i_sig;
`endif

  logic       prev_q;
  logic       prev_d;
  logic [1:0] arm_q;
  logic [1:0] arm_d;

  // The detector stays disarmed until prev_q holds a real post-reset sample,
  // so a level already high at reset release is not mistaken for an edge.
  always_comb begin
    prev_d = cur;
    arm_d  = (arm_q == ARM_CYCLES) ? arm_q : arm_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 1'b0;
      arm_q  <= 2'd0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  assign o_rise = cur & ~prev_q & (arm_q == ARM_CYCLES);

endmodule

`default_nettype wire

// File: rtl/chrono_counter.sv
//------------------------------------------------------------------------------
// chrono_counter : start/stop gated min:sec.cent interval timer (CHRONO_SYNC_EN
//                  adds input synchronizers in edge_sync)
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module chrono_counter
  import chrono_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_clear,
  output logic [MIN_W-1:0]  o_min,
  output logic [SEG_W-1:0]  o_seg,
  output logic [CENT_W-1:0] o_cent,
  output logic              o_running,
  output logic              o_done,
  output logic              o_overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);

  logic start_rise;
  logic stop_rise;

  edge_sync u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (i_start),
    .o_rise (start_rise)
  );

  edge_sync u_stop_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (i_stop),
    .o_rise (stop_rise)
  );

  logic [1:0]        state_q,    state_d;
  logic [PW-1:0]     presc_q,    presc_d;
  logic [MIN_W-1:0]  min_q,      min_d;
  logic [SEG_W-1:0]  seg_q,      seg_d;
  logic [CENT_W-1:0] cent_q,     cent_d;
  logic              running_q,  running_d;
  logic              done_q,     done_d;
  logic              overflow_q, overflow_d;
  logic              tick;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    min_d      = min_q;
    seg_d      = seg_q;
    cent_d     = cent_q;
    overflow_d = overflow_q;
    tick       = (state_q == S_RUN) && (presc_q == PRESC_TC);

    if (i_clear) begin
      state_d    = S_IDLE;
      presc_d    = '0;
      min_d      = '0;
      seg_d      = '0;
      cent_d     = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          min_d   = '0;
          seg_d   = '0;
          cent_d  = '0;
          if (start_rise) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          // A stop edge wins over a coincident tick, so that tick is dropped.
          if (stop_rise) begin
            state_d = S_STOP;
          end else if (tick) begin
            if (at_full_scale(min_q, seg_q, cent_q)) begin
              state_d    = S_STOP;
              overflow_d = 1'b1;
            end else if (cent_q == CENT_MAX) begin
              cent_d = '0;
              if (seg_q == SEG_MAX) begin
                seg_d = '0;
                min_d = min_q + MIN_W'(1);
              end else begin
                seg_d = seg_q + SEG_W'(1);
              end
            end else begin
              cent_d = cent_q + CENT_W'(1);
            end
          end
        end
        S_STOP: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_STOP) && (state_q != S_STOP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      min_q      <= '0;
      seg_q      <= '0;
      cent_q     <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      min_q      <= min_d;
      seg_q      <= seg_d;
      cent_q     <= cent_d;
      running_q  <= running_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_min      = min_q;
  assign o_seg      = seg_q;
  assign o_cent     = cent_q;
  assign o_running  = running_q;
  assign o_done     = done_q;
  assign o_overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_chrono_counter.sv
//------------------------------------------------------------------------------
// tb_chrono_counter : directed self-checking bench for chrono_counter
//                     (latency expectations follow CHRONO_SYNC_EN)
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_chrono_counter;

`ifdef CHRONO_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic clk_b = 1'b0;
  always #5 clk   = ~clk;
  always #2 clk_b = ~clk_b;

  // Instance A: DIV = 10
  logic       reset_a, start_a, stop_a, clear_a;
  logic [3:0] min_a;
  logic [5:0] seg_a;
  logic [6:0] cent_a;
  logic       running_a, done_a, ovf_a;

  // Instance B: DIV = 2, for rollover and saturation runs
  logic       reset_b, start_b, stop_b, clear_b;
  logic [3:0] min_b;
  logic [5:0] seg_b;
  logic [6:0] cent_b;
  logic       running_b, done_b, ovf_b;

  chrono_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .i_start    (start_a),
    .i_stop     (stop_a),
    .i_clear    (clear_a),
    .o_min      (min_a),
    .o_seg      (seg_a),
    .o_cent     (cent_a),
    .o_running  (running_a),
    .o_done     (done_a),
    .o_overflow (ovf_a)
  );

  chrono_counter #(.CLK_HZ(200), .TICK_HZ(100)) dut_b (
    .clk        (clk_b),
    .reset      (reset_b),
    .i_start    (start_b),
    .i_stop     (stop_b),
    .i_clear    (clear_b),
    .o_min      (min_b),
    .o_seg      (seg_b),
    .o_cent     (cent_b),
    .o_running  (running_b),
    .o_done     (done_b),
    .o_overflow (ovf_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_a(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_b(input int n);
    repeat (n) begin
      @(posedge clk_b);
      #1;
    end
  endtask

  task automatic check_time_a(input string tag, input int m, input int s, input int c);
    check({tag, "_min"},  32'(min_a),  32'(m));
    check({tag, "_seg"},  32'(seg_a),  32'(s));
    check({tag, "_cent"}, 32'(cent_a), 32'(c));
  endtask

  task automatic check_time_b(input string tag, input int m, input int s, input int c);
    check({tag, "_min"},  32'(min_b),  32'(m));
    check({tag, "_seg"},  32'(seg_b),  32'(s));
    check({tag, "_cent"}, 32'(cent_b), 32'(c));
  endtask

  task automatic clear_a_pulse();
    start_a = 1'b0;
    stop_a  = 1'b0;
    clear_a = 1'b1;
    step_a(1);
    clear_a = 1'b0;
    step_a(4);
  endtask

  task automatic begin_run_a();
    start_a = 1'b1;
    step_a(LAT);
    start_a = 1'b0;
  endtask

  task automatic run_a();
    // Reset held for 3 cycles while inputs toggle
    reset_a = 1'b0;
    start_a = 1'b0;
    stop_a  = 1'b0;
    clear_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_a = i[0];
      stop_a  = ~i[0];
      clear_a = i[1];
      step_a(1);
    end
    check("rst_running", 32'(running_a), 32'd0);
    check("rst_done",    32'(done_a),    32'd0);
    check("rst_ovf",     32'(ovf_a),     32'd0);
    check_time_a("rst", 0, 0, 0);

    // Start already high when reset releases: no edge
    start_a = 1'b1;
    stop_a  = 1'b0;
    clear_a = 1'b0;
    reset_a = 1'b1;
    step_a(6);
    check("release_no_edge", 32'(running_a), 32'd0);
    start_a = 1'b0;
    step_a(4);

    // Basic measurement: 150 ticks
    start_a = 1'b1;
    step_a(LAT - 1);
    check("start_latency_pre", 32'(running_a), 32'd0);
    step_a(1);
    check("start_latency", 32'(running_a), 32'd1);
    start_a = 1'b0;
    step_a(1500 - (LAT - 1));
    stop_a = 1'b1;
    step_a(LAT - 1);
    check("basic_done_pre", 32'(done_a), 32'd0);
    step_a(1);
    check("basic_done", 32'(done_a), 32'd1);
    check("basic_running", 32'(running_a), 32'd0);
    check_time_a("basic", 0, 1, 50);
    step_a(1);
    check("basic_done_fall", 32'(done_a), 32'd0);
    stop_a = 1'b0;
    step_a(30);
    check_time_a("basic_hold", 0, 1, 50);
    check("basic_ovf", 32'(ovf_a), 32'd0);
    clear_a_pulse();
    check_time_a("clr1", 0, 0, 0);

    // Stop edge on the same cycle as the 25th tick
    begin_run_a();
    step_a(249 - (LAT - 1));
    stop_a = 1'b1;
    step_a(LAT);
    check("coinc_done", 32'(done_a), 32'd1);
    check_time_a("coinc", 0, 0, 24);
    clear_a_pulse();

    // Start and stop together in idle: run continues
    start_a = 1'b1;
    stop_a  = 1'b1;
    step_a(LAT);
    check("both_running", 32'(running_a), 32'd1);
    check("both_done", 32'(done_a), 32'd0);
    start_a = 1'b0;
    stop_a  = 1'b0;
    step_a(20);
    check("both_still_running", 32'(running_a), 32'd1);
    check("both_cent", 32'(cent_a), 32'd2);
    clear_a_pulse();

    // Clear at 0:03.07 while running
    begin_run_a();
    step_a(3070);
    check_time_a("pre_clear", 0, 3, 7);
    clear_a = 1'b1;
    step_a(1);
    clear_a = 1'b0;
    check("clear_running", 32'(running_a), 32'd0);
    check("clear_done", 32'(done_a), 32'd0);
    check_time_a("clear", 0, 0, 0);
    step_a(1);
    check("clear_done_next", 32'(done_a), 32'd0);
    step_a(20);
    check("clear_idle_cent", 32'(cent_a), 32'd0);
    step_a(4);

    // Reset during run
    begin_run_a();
    step_a(55);
    check("pre_reset_cent", 32'(cent_a), 32'd5);
    reset_a = 1'b0;
    step_a(1);
    check("midrst_running", 32'(running_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    check_time_a("midrst", 0, 0, 0);
    reset_a = 1'b1;
    step_a(1);
    check("midrst_done_next", 32'(done_a), 32'd0);
    step_a(5);

    // Start edge in stop state leaves the count alone
    begin_run_a();
    step_a(30 - (LAT - 1));
    stop_a = 1'b1;
    step_a(LAT);
    check("stopped_done", 32'(done_a), 32'd1);
    check("stopped_cent", 32'(cent_a), 32'd3);
    stop_a = 1'b0;
    step_a(5);
    start_a = 1'b1;
    step_a(LAT + 20);
    check("restart_running", 32'(running_a), 32'd0);
    check("restart_done", 32'(done_a), 32'd0);
    check_time_a("restart", 0, 0, 3);
    clear_a_pulse();
  endtask

  task automatic run_b();
    int k;
    int done_cnt;
    reset_b  = 1'b0;
    start_b  = 1'b0;
    stop_b   = 1'b0;
    clear_b  = 1'b0;
    done_cnt = 0;
    step_b(3);
    reset_b = 1'b1;
    step_b(4);
    start_b = 1'b1;
    k = 0;
    while (running_b !== 1'b1 && k < 10) begin
      step_b(1);
      k++;
    end
    check("b_start", 32'(running_b), 32'd1);
    start_b = 1'b0;

    step_b(11998);
    check_time_b("roll_5999", 0, 59, 99);
    step_b(2);
    check_time_b("roll_6000", 1, 0, 0);

    k = 12000;
    while (running_b === 1'b1 && k < 120010) begin
      step_b(1);
      k++;
      if (done_b === 1'b1) done_cnt++;
    end
    check("sat_step", 32'(k), 32'd120000);
    check("sat_done", 32'(done_b), 32'd1);
    check("sat_ovf", 32'(ovf_b), 32'd1);
    check("sat_running", 32'(running_b), 32'd0);
    check_time_b("sat", 9, 59, 99);
    for (int i = 0; i < 40; i++) begin
      step_b(1);
      if (done_b === 1'b1) done_cnt++;
    end
    check("sat_done_count", 32'(done_cnt), 32'd1);
    check_time_b("sat_hold", 9, 59, 99);
    check("sat_ovf_hold", 32'(ovf_b), 32'd1);
    clear_b = 1'b1;
    step_b(1);
    clear_b = 1'b0;
    check("sat_ovf_clear", 32'(ovf_b), 32'd0);
    check_time_b("sat_clear", 0, 0, 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
